int_controller: RTL and testbench
=================================

// Module: int_controller
// PURPOSE
//   Vectored interrupt controller for the single-cycle CPU. Latches rising edges on
//   N_IRQ external lines, applies a software mask, and picks the highest-priority
//   eligible line. It raises a request to the control unit, which pushes the return
//   PC and loads the vector. Nesting is blocked until the control unit signals reti.
// PARAMETERS
//   N_IRQ      4        number of interrupt lines (id width fixed at 2 bits, N_IRQ<=4)
//   VEC_W      10       vector / PC width in bits
//   VEC_BASE   10'h3F0  address of the line-0 handler
//   VEC_STRIDE 4        address distance between consecutive handlers
// PORTS
//   clk         in   1      clock, all state on rising edge
//   reset       in   1      synchronous, active-high
//   irq         in   N_IRQ  interrupt lines, synchronous to clk, rising-edge triggered
//   mask_we     in   1      write strobe for mask
//   mask_in     in   N_IRQ  new mask value (1 = enabled)
//   ack         in   1      control unit pushed return PC and loaded int_vec this cycle
//   reti        in   1      control unit executed return-from-interrupt
//   int_req     out  1      interrupt request to control unit
//   int_vec     out  VEC_W  handler address, VEC_BASE + int_id*VEC_STRIDE
//   int_id      out  2      line being requested or serviced
//   int_active  out  1      handler in progress
//   pending     out  N_IRQ  latched, unserviced edges
//   mask        out  N_IRQ  current mask register
// BEHAVIOUR
//   Reset: state IDLE, pending=0, mask=0, int_req=0, int_active=0, int_id=0,
//   int_vec=VEC_BASE. While reset is high, irq_q<=irq, so lines high at reset
//   release produce no edge. Reset mid-service drops all state; nothing is replayed.
//   Edge detect: rise = irq & ~irq_q. pending <= (pending & ~clr) | rise. clr is the
//   one-hot of int_id on an accepted ack. Set wins over clear on the same line.
//   Pending latches independently of the mask. Eligible lines are pending & mask.
//   mask_we writes mask at the edge; the new mask is used from the next cycle.
//   Priority: fixed, lowest index wins.
//   FSM (registered outputs):
//     IDLE: if any line is eligible, latch int_id/int_vec and go to REQ.
//     REQ:  int_req=1; int_id and int_vec held stable. The request is committed:
//           mask changes and newly pending lines do not alter or withdraw it.
//           On ack: clear pending[int_id], go to SERV.
//     SERV: int_active=1, int_req=0, no new request (no nesting). On reti go to IDLE.
//   Latency: irq first sampled high at edge k -> pending set at k -> int_req high
//   after edge k+1. After reti at edge r, the next int_req can rise after edge r+1.
//   ack outside REQ and reti outside SERV are ignored. ack and reti together in REQ
//   are treated as ack only.
//   Width: int_vec = VEC_BASE + id*VEC_STRIDE truncated to VEC_W. An elaboration
//   check enforces VEC_BASE + (N_IRQ-1)*VEC_STRIDE < 2**VEC_W.
// STRUCTURE
//   Shared header cpu_defs.vh: FSM state encodings (IDLE/REQ/SERV) and the
//   VEC_BASE/VEC_STRIDE defaults, so the control unit decodes the same map.
//   One sub-module, prio_enc: N_IRQ-bit fixed-priority encoder (valid + 2-bit id).
//   Edge detect, pending/mask registers and the FSM stay in int_controller.
// TESTING
//   1 irq=0010 held through reset, mask<=1111 -> pending stays 0000, int_req stays 0.
//   2 mask=1111, 1-cycle pulse on irq[2] -> pending=0100; int_req=1, int_id=2,
//     int_vec=0x3F8 after next edge; ack held low 5 cycles, request holds;
//     ack -> pending=0000, int_active=1.
//   3 irq[3] and irq[1] rise together -> id 1 (0x3F4) first; after reti,
//     id 3 (0x3FC) requested one cycle later.
//   4 irq[0] rises in SERV -> pending=0001, int_req=0 until reti; then id 0, 0x3F0.
//   5 mask=1110, irq[0] rises -> pending=0001, no request; write mask=1111 ->
//     int_req rises on the edge after the mask takes effect.
//   6 irq[2] re-rises in the ack cycle of id 2 -> pending[2] stays 1, serviced again
//     after reti; reset asserted in SERV -> all outputs return to reset values.

Source files
------------

// File: rtl/int_controller_pkg.sv
// rtl/int_controller_pkg.sv - shared state encodings and vector map for the interrupt controller
package int_controller_pkg;

  localparam int ID_W           = 2;
  localparam int N_IRQ_DEF      = 4;
  localparam int VEC_W_DEF      = 10;
  localparam int VEC_BASE_DEF   = 'h3F0;
  localparam int VEC_STRIDE_DEF = 4;

  // The control unit decodes these same encodings, so keep the values fixed.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SERV = 2'd2
  } int_state_t;

  function automatic int vec_addr(input int base, input int stride, input logic [ID_W-1:0] id);
    return base + int'(id) * stride;
  endfunction

endpackage

// File: rtl/int_controller_if.sv
// rtl/int_controller_if.sv - interrupt lines, mask write and control-unit handshake bundle
interface int_controller_if
  import int_controller_pkg::*;
#(
  parameter int N_IRQ = N_IRQ_DEF,
  parameter int VEC_W = VEC_W_DEF
);

  logic [N_IRQ-1:0] irq;
  logic             mask_we;
  logic [N_IRQ-1:0] mask_in;
  logic             ack;
  logic             reti;
  logic             int_req;
  logic [VEC_W-1:0] int_vec;
  logic [ID_W-1:0]  int_id;
  logic             int_active;
  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] mask;

  modport master (
    input  irq, mask_we, mask_in, ack, reti,
    output int_req, int_vec, int_id, int_active, pending, mask
  );

  modport slave (
    output irq, mask_we, mask_in, ack, reti,
    input  int_req, int_vec, int_id, int_active, pending, mask
  );

endinterface

// File: rtl/int_controller_prio_enc.sv
// rtl/int_controller_prio_enc.sv - fixed-priority encoder, lowest index wins
module int_controller_prio_enc
  import int_controller_pkg::*;
#(
  parameter int N = N_IRQ_DEF
) (
  input  logic [N-1:0]    req,
  output logic            valid,
  output logic [ID_W-1:0] id
);

  // Scan downwards so the lowest set index is the last assignment to stick.
  always_comb begin
    valid = 1'b0;
    id    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        id    = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/int_controller.sv
// rtl/int_controller.sv - vectored interrupt controller: edge latch, mask, priority pick, no nesting
module int_controller
  import int_controller_pkg::*;
#(
  parameter int N_IRQ      = N_IRQ_DEF,
  parameter int VEC_W      = VEC_W_DEF,
  parameter int VEC_BASE   = VEC_BASE_DEF,
  parameter int VEC_STRIDE = VEC_STRIDE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  int_controller_if.master  bus
);

  localparam longint LAST_VEC = longint'(VEC_BASE) + longint'(N_IRQ - 1) * longint'(VEC_STRIDE);
  localparam longint VEC_SPAN = longint'(1) << VEC_W;

  generate
    if (N_IRQ < 1 || N_IRQ > 4) begin : g_bad_n_irq
      $error("int_controller: N_IRQ must be 1..4");
    end
    if (LAST_VEC >= VEC_SPAN) begin : g_bad_vec_range
      $error("int_controller: highest handler address does not fit in VEC_W bits");
    end
  endgenerate

  int_state_t       state, state_nxt;
  logic [N_IRQ-1:0] irq_q;
  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] pending_r;
  logic [N_IRQ-1:0] mask_r;
  logic [N_IRQ-1:0] clr;
  logic [N_IRQ-1:0] eligible;
  logic             prio_valid;
  logic [ID_W-1:0]  prio_id;
  logic [ID_W-1:0]  id_r;
  logic [VEC_W-1:0] vec_r;
  logic             ack_ok;

  assign rise     = bus.irq & ~irq_q;
  assign eligible = pending_r & mask_r;
  assign ack_ok   = (state == ST_REQ) && bus.ack;
  assign clr      = ack_ok ? (N_IRQ'(1) << id_r) : '0;

  int_controller_prio_enc #(.N(N_IRQ)) u_prio_enc (
    .req   (eligible),
    .valid (prio_valid),
    .id    (prio_id)
  );

  // irq_q tracks the lines even in reset so a line already high at release is not an edge.
  always_ff @(posedge clk) begin
    irq_q <= bus.irq;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_r <= '0;
      mask_r    <= '0;
    end else begin
      pending_r <= (pending_r & ~clr) | rise;
      if (bus.mask_we) begin
        mask_r <= bus.mask_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (prio_valid) state_nxt = ST_REQ;
      ST_REQ:  if (bus.ack)    state_nxt = ST_SERV;
      ST_SERV: if (bus.reti)   state_nxt = ST_IDLE;
      default:                 state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.int_req    = 1'b0;
    bus.int_active = 1'b0;
    case (state)
      ST_REQ:  bus.int_req    = 1'b1;
      ST_SERV: bus.int_active = 1'b1;
      default: ;
    endcase
  end

  // id/vector are captured once on the IDLE->REQ step and then held, keeping the request committed.
  always_ff @(posedge clk) begin
    if (reset) begin
      id_r  <= '0;
      vec_r <= VEC_W'(VEC_BASE);
    end else if (state == ST_IDLE && prio_valid) begin
      id_r  <= prio_id;
      vec_r <= VEC_W'(vec_addr(VEC_BASE, VEC_STRIDE, prio_id));
    end
  end

  assign bus.int_id  = id_r;
  assign bus.int_vec = vec_r;
  assign bus.pending = pending_r;
  assign bus.mask    = mask_r;

endmodule

// File: tb/tb_int_controller.sv
// tb/tb_int_controller.sv - table-driven scoreboard bench for int_controller
module tb_int_controller;

  logic clk;
  logic reset;

  int_controller_if #(.N_IRQ(4), .VEC_W(10)) bus ();

  int_controller #(
    .N_IRQ      (4),
    .VEC_W      (10),
    .VEC_BASE   ('h3F0),
    .VEC_STRIDE (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       req;
    logic [1:0] id;
    logic [9:0] vec;
    logic       act;
    logic [3:0] pend;
    logic [3:0] msk;
  } exp_t;

  typedef struct packed {
    logic       rst;
    logic [3:0] irq;
    logic       mwe;
    logic [3:0] min;
    logic       ack;
    logic       reti;
    exp_t       exp;
  } row_t;

  row_t tbl[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic add(input logic rst, input logic [3:0] irq, input logic mwe, input logic [3:0] min,
                     input logic ack, input logic reti, input logic req, input logic [1:0] id,
                     input logic [9:0] vec, input logic act, input logic [3:0] pend, input logic [3:0] msk);
    row_t r;
    r.rst = rst; r.irq = irq; r.mwe = mwe; r.min = min; r.ack = ack; r.reti = reti;
    r.exp = '{req: req, id: id, vec: vec, act: act, pend: pend, msk: msk};
    tbl.push_back(r);
  endtask

  function automatic exp_t sample();
    exp_t g;
    g = '{req: bus.int_req, id: bus.int_id, vec: bus.int_vec, act: bus.int_active,
          pend: bus.pending, msk: bus.mask};
    return g;
  endfunction

  task automatic check(input string name, input exp_t got, input exp_t want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got req=%b id=%0d vec=%h act=%b pend=%b mask=%b, want req=%b id=%0d vec=%h act=%b pend=%b mask=%b",
               name, got.req, got.id, got.vec, got.act, got.pend, got.msk,
               want.req, want.id, want.vec, want.act, want.pend, want.msk);
    end
  endtask

  task automatic drive(input logic rst, input logic [3:0] irq, input logic mwe, input logic [3:0] min,
                       input logic ack, input logic reti);
    reset       = rst;
    bus.irq     = irq;
    bus.mask_we = mwe;
    bus.mask_in = min;
    bus.ack     = ack;
    bus.reti    = reti;
  endtask

  initial begin
    exp_t want;
    exp_t got;
    int   waited;

    drive(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);

    //   rst irq      mwe min      ack reti | req id vec      act pend     mask
    // lines held high through reset must not look like edges
    add(1, 4'b0010, 0, 4'b0000, 0, 0,   0, 0, 10'h3F0, 0, 4'b0000, 4'b0000);
    add(1, 4'b0010, 0, 4'b0000, 0, 0,   0, 0, 10'h3F0, 0, 4'b0000, 4'b0000);
    add(0, 4'b0010, 1, 4'b1111, 0, 0,   0, 0, 10'h3F0, 0, 4'b0000, 4'b1111);
    add(0, 4'b0010, 0, 4'b0000, 0, 0,   0, 0, 10'h3F0, 0, 4'b0000, 4'b1111);
    add(0, 4'b0000, 0, 4'b0000, 0, 0,   0, 0, 10'h3F0, 0, 4'b0000, 4'b1111);
    // one-cycle pulse on irq[2], ack withheld for five cycles
    add(0, 4'b0100, 0, 4'b0000, 0, 0,   0, 0, 10'h3F0, 0, 4'b0100, 4'b1111);
    add(0, 4'b0000, 0, 4'b0000, 0, 0,   1, 2, 10'h3F8, 0, 4'b0100, 4'b1111);
    for (int i = 0; i < 5; i++)
      add(0, 4'b0000, 0, 4'b0000, 0, 0, 1, 2, 10'h3F8, 0, 4'b0100, 4'b1111);
    add(0, 4'b0000, 0, 4'b0000, 1, 0,   0, 2, 10'h3F8, 1, 4'b0000, 4'b1111);
    add(0, 4'b0000, 0, 4'b0000, 0, 0,   0, 2, 10'h3F8, 1, 4'b0000, 4'b1111);
    add(0, 4'b0000, 0, 4'b0000, 0, 1,   0, 2, 10'h3F8, 0, 4'b0000, 4'b1111);
    // simultaneous irq[3] and irq[1]: lower index first
    add(0, 4'b1010, 0, 4'b0000, 0, 0,   0, 2, 10'h3F8, 0, 4'b1010, 4'b1111);
    add(0, 4'b0000, 0, 4'b0000, 0, 0,   1, 1, 10'h3F4, 0, 4'b1010, 4'b1111);
    add(0, 4'b0000, 0, 4'b0000, 1, 0,   0, 1, 10'h3F4, 1, 4'b1000, 4'b1111);
    add(0, 4'b0000, 0, 4'b0000, 0, 1,   0, 1, 10'h3F4, 0, 4'b1000, 4'b1111);
    add(0, 4'b0000, 0, 4'b0000, 0, 0,   1, 3, 10'h3FC, 0, 4'b1000, 4'b1111);
    add(0, 4'b0000, 0, 4'b0000, 1, 0,   0, 3, 10'h3FC, 1, 4'b0000, 4'b1111);
    // irq[0] during service waits for reti
    add(0, 4'b0001, 0, 4'b0000, 0, 0,   0, 3, 10'h3FC, 1, 4'b0001, 4'b1111);
    add(0, 4'b0000, 0, 4'b0000, 0, 0,   0, 3, 10'h3FC, 1, 4'b0001, 4'b1111);
    add(0, 4'b0000, 0, 4'b0000, 0, 1,   0, 3, 10'h3FC, 0, 4'b0001, 4'b1111);
    add(0, 4'b0000, 0, 4'b0000, 0, 0,   1, 0, 10'h3F0, 0, 4'b0001, 4'b1111);
    add(0, 4'b0000, 0, 4'b0000, 1, 0,   0, 0, 10'h3F0, 1, 4'b0000, 4'b1111);
    add(0, 4'b0000, 0, 4'b0000, 0, 1,   0, 0, 10'h3F0, 0, 4'b0000, 4'b1111);
    // masked line latches but does not request until unmasked
    add(0, 4'b0000, 1, 4'b1110, 0, 0,   0, 0, 10'h3F0, 0, 4'b0000, 4'b1110);
    add(0, 4'b0001, 0, 4'b0000, 0, 0,   0, 0, 10'h3F0, 0, 4'b0001, 4'b1110);
    add(0, 4'b0000, 0, 4'b0000, 0, 0,   0, 0, 10'h3F0, 0, 4'b0001, 4'b1110);
    add(0, 4'b0000, 0, 4'b0000, 0, 0,   0, 0, 10'h3F0, 0, 4'b0001, 4'b1110);
    add(0, 4'b0000, 1, 4'b1111, 0, 0,   0, 0, 10'h3F0, 0, 4'b0001, 4'b1111);
    add(0, 4'b0000, 0, 4'b0000, 0, 0,   1, 0, 10'h3F0, 0, 4'b0001, 4'b1111);
    // committed request survives a mask clear and a new edge
    add(0, 4'b0010, 1, 4'b0000, 0, 0,   1, 0, 10'h3F0, 0, 4'b0011, 4'b0000);
    add(0, 4'b0000, 0, 4'b0000, 1, 0,   0, 0, 10'h3F0, 1, 4'b0010, 4'b0000);
    add(0, 4'b0000, 1, 4'b1111, 0, 1,   0, 0, 10'h3F0, 0, 4'b0010, 4'b1111);
    add(0, 4'b0000, 0, 4'b0000, 0, 0,   1, 1, 10'h3F4, 0, 4'b0010, 4'b1111);
    add(0, 4'b0000, 0, 4'b0000, 1, 0,   0, 1, 10'h3F4, 1, 4'b0000, 4'b1111);
    // ack outside REQ and reti outside SERV are ignored
    add(0, 4'b0000, 0, 4'b0000, 1, 0,   0, 1, 10'h3F4, 1, 4'b0000, 4'b1111);
    add(0, 4'b0000, 0, 4'b0000, 0, 1,   0, 1, 10'h3F4, 0, 4'b0000, 4'b1111);
    add(0, 4'b0000, 0, 4'b0000, 0, 1,   0, 1, 10'h3F4, 0, 4'b0000, 4'b1111);
    // re-rise of irq[2] in its own ack cycle: set beats clear
    add(0, 4'b0100, 0, 4'b0000, 0, 0,   0, 1, 10'h3F4, 0, 4'b0100, 4'b1111);
    add(0, 4'b0000, 0, 4'b0000, 0, 0,   1, 2, 10'h3F8, 0, 4'b0100, 4'b1111);
    add(0, 4'b0100, 0, 4'b0000, 1, 0,   0, 2, 10'h3F8, 1, 4'b0100, 4'b1111);
    add(0, 4'b0000, 0, 4'b0000, 0, 0,   0, 2, 10'h3F8, 1, 4'b0100, 4'b1111);
    add(0, 4'b0000, 0, 4'b0000, 0, 1,   0, 2, 10'h3F8, 0, 4'b0100, 4'b1111);
    add(0, 4'b0000, 0, 4'b0000, 0, 0,   1, 2, 10'h3F8, 0, 4'b0100, 4'b1111);
    // ack with reti in REQ acts as ack only
    add(0, 4'b0000, 0, 4'b0000, 1, 1,   0, 2, 10'h3F8, 1, 4'b0000, 4'b1111);
    add(0, 4'b0001, 0, 4'b0000, 0, 0,   0, 2, 10'h3F8, 1, 4'b0001, 4'b1111);
    // reset mid-service drops everything, nothing replayed afterwards
    add(1, 4'b0000, 0, 4'b0000, 0, 0,   0, 0, 10'h3F0, 0, 4'b0000, 4'b0000);
    add(0, 4'b0000, 0, 4'b0000, 0, 0,   0, 0, 10'h3F0, 0, 4'b0000, 4'b0000);
    add(0, 4'b0000, 0, 4'b0000, 0, 0,   0, 0, 10'h3F0, 0, 4'b0000, 4'b0000);

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].irq, tbl[i].mwe, tbl[i].min, tbl[i].ack, tbl[i].reti);
      sb.push_back(tbl[i].exp);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL scoreboard_underflow row %0d", i);
      end else begin
        want = sb.pop_front();
        got  = sample();
        check($sformatf("row%0d", i), got, want);
      end
    end

    // hand sequence: unmask, pulse irq[3], request must appear two edges after the pulse edge
    @(negedge clk);
    drive(1'b0, 4'b0000, 1'b1, 4'b1111, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 4'b1000, 1'b0, 4'b0000, 1'b0, 1'b0);
    sb.push_back('{req: 1'b1, id: 2'd3, vec: 10'h3FC, act: 1'b0, pend: 4'b1000, msk: 4'b1111});
    @(negedge clk);
    drive(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
    waited = 1;
    while (!bus.int_req && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    want = sb.pop_front();
    got  = sample();
    check("irq3_request", got, want);
    n_cmp++;
    if (waited != 2) begin
      n_err++;
      $display("FAIL irq3_latency: got %0d edges, want 2", waited);
    end

    drive(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
    check("irq3_done", sample(),
          '{req: 1'b0, id: 2'd3, vec: 10'h3FC, act: 1'b0, pend: 4'b0000, msk: 4'b1111});

    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_leftover: got %0d entries, want 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
